kanagawa_hal_reset_sequencer: RTL and testbench

KANAGAWA_HAL_RESET_SEQUENCER -- requirements
Module: kanagawa_hal_reset_sequencer

---
 rtl/kanagawa_hal_reset_sequencer.sv | 126 ++++++++++++
 tb/tb_kanagawa_hal_reset_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/kanagawa_hal_reset_sequencer.sv
// Staged reset release: synchronises arst, holds every domain in reset for HOLD_CYCLES,
// then releases domains one at a time, each waiting for the previous ready or a timeout.
module kanagawa_hal_reset_sequencer #(
   parameter int NUM_STAGES    = 4,
   parameter int SYNC_DEPTH    = 2,
   parameter int HOLD_CYCLES   = 16,
   parameter int STAGE_TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  sw_rst_req,
   input  logic [NUM_STAGES-1:0] ready_in,
   output logic [NUM_STAGES-1:0] rst_out,
   output logic                  all_ready,
   output logic                  busy,
   output logic [NUM_STAGES-1:0] timeout_err
);

   localparam int IDXW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam logic [15:0]     HOLD_LOAD = 16'(HOLD_CYCLES - 1);
   localparam logic [15:0]     TMO_LOAD  = 16'(STAGE_TIMEOUT - 1);
   localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NUM_STAGES - 1);

   typedef enum logic [1:0] {
      SYNC = 2'd0,
      HOLD = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   logic [SYNC_DEPTH-1:0] sync_r;
   logic                  rst_sync_s;
   state_t                state_r;
   logic [IDXW-1:0]       idx_r;
   logic [IDXW-1:0]       nxt_idx_s;
   logic [15:0]           cnt_r;
   logic [NUM_STAGES-1:0] rst_out_r;
   logic                  all_ready_r;
   logic                  busy_r;
   logic [NUM_STAGES-1:0] timeout_err_r;

   // Reset-deassertion synchronizer: async set, zeros shift in on each edge
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         sync_r <= '1;
      end else begin
         sync_r <= {sync_r[SYNC_DEPTH-2:0], 1'b0};
      end
   end

   assign rst_sync_s = sync_r[SYNC_DEPTH-1];
   assign nxt_idx_s  = idx_r + IDXW'(1);

   // Sequencing FSM with registered outputs
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_r       <= SYNC;
         idx_r         <= '0;
         cnt_r         <= 16'd0;
         rst_out_r     <= '1;
         all_ready_r   <= 1'b0;
         busy_r        <= 1'b1;
         timeout_err_r <= '0;
      end else if (sw_rst_req && (state_r != SYNC)) begin
         // Soft rerun keeps the sticky timeout flags
         state_r     <= HOLD;
         idx_r       <= '0;
         cnt_r       <= HOLD_LOAD;
         rst_out_r   <= '1;
         all_ready_r <= 1'b0;
         busy_r      <= 1'b1;
      end else begin
         case (state_r)
            SYNC: begin
               if (!rst_sync_s) begin
                  state_r <= HOLD;
                  cnt_r   <= HOLD_LOAD;
               end
            end
            HOLD: begin
               if (cnt_r == 16'd0) begin
                  rst_out_r[0] <= 1'b0;
                  idx_r        <= '0;
                  cnt_r        <= TMO_LOAD;
                  state_r      <= WAIT;
               end else begin
                  cnt_r <= cnt_r - 16'd1;
               end
            end
            WAIT: begin
               // Ready wins over a coincident timeout
               if (ready_in[idx_r] || (cnt_r == 16'd0)) begin
                  if (!ready_in[idx_r]) begin
                     timeout_err_r[idx_r] <= 1'b1;
                  end
                  if (idx_r == LAST_IDX) begin
                     state_r     <= DONE;
                     all_ready_r <= 1'b1;
                     busy_r      <= 1'b0;
                  end else begin
                     rst_out_r[nxt_idx_s] <= 1'b0;
                     idx_r                <= nxt_idx_s;
                     cnt_r                <= TMO_LOAD;
                  end
               end else begin
                  cnt_r <= cnt_r - 16'd1;
               end
            end
            DONE: begin
               rst_out_r   <= '0;
               all_ready_r <= 1'b1;
               busy_r      <= 1'b0;
            end
            default: begin
               state_r <= SYNC;
            end
         endcase
      end
   end

   assign rst_out     = rst_out_r;
   assign all_ready   = all_ready_r;
   assign busy        = busy_r;
   assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_kanagawa_hal_reset_sequencer.sv
// Bench for kanagawa_hal_reset_sequencer: release edges predicted arithmetically from
// per-stage ready rise edges and compared against the DUT on every clock edge.
module tb_kanagawa_hal_reset_sequencer;

   localparam int NS   = 3;
   localparam int SD   = 2;
   localparam int HC   = 4;
   localparam int TMO  = 8;
   localparam int PWR0 = SD + HC + 1;

   logic          clk;
   logic          arst;
   logic          sw_rst_req;
   logic [NS-1:0] ready_in;
   logic [NS-1:0] rst_out;
   logic          all_ready;
   logic          busy;
   logic [NS-1:0] timeout_err;

   int            n_cmp;
   int            n_bad;
   logic [NS-1:0] err_model;

   kanagawa_hal_reset_sequencer #(
      .NUM_STAGES(NS),
      .SYNC_DEPTH(SD),
      .HOLD_CYCLES(HC),
      .STAGE_TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .arst(arst),
      .sw_rst_req(sw_rst_req),
      .ready_in(ready_in),
      .rst_out(rst_out),
      .all_ready(all_ready),
      .busy(busy),
      .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Assert arst for one edge, release it just after a rising edge (next edge is edge 1)
   task automatic apply_arst();
      arst       = 1'b1;
      sw_rst_req = 1'b0;
      ready_in   = '0;
      err_model  = '0;
      @(posedge clk);
      #1;
      arst = 1'b0;
   endtask

   // Drive one sequence: stage i's ready goes high from edge rise_i (edges counted from the
   // reference point); stage 0 releases at rel0. Checks every edge up to stop or done+3.
   task automatic play_sequence(input string name, input int rel0, input int r0, input int r1,
                                input int r2, input int stop);
      int rise[3];
      int rel[3];
      int adv[3];
      logic [NS-1:0] tmo;
      logic [NS-1:0] exp_rst;
      logic [NS-1:0] exp_err;
      int last;
      rise[0] = r0;
      rise[1] = r1;
      rise[2] = r2;
      rel[0]  = rel0;
      for (int i = 0; i < NS; i++) begin
         if (rise[i] <= rel[i] + TMO) begin
            adv[i] = (rise[i] > rel[i] + 1) ? rise[i] : rel[i] + 1;
            tmo[i] = 1'b0;
         end else begin
            adv[i] = rel[i] + TMO;
            tmo[i] = 1'b1;
         end
         if (i < NS - 1) rel[i+1] = adv[i];
      end
      last = adv[NS-1] + 3;
      if (stop < last) last = stop;
      for (int e = 1; e <= last; e++) begin
         for (int i = 0; i < NS; i++) ready_in[i] = (e >= rise[i]);
         @(posedge clk);
         #1;
         for (int i = 0; i < NS; i++) begin
            exp_rst[i] = (e < rel[i]);
            exp_err[i] = err_model[i] | (tmo[i] & (e >= adv[i]));
         end
         n_cmp++;
         if (rst_out !== exp_rst) begin
            n_bad++;
            $display("FAIL %s rst_out edge %0d: got %b expected %b", name, e, rst_out, exp_rst);
         end
         n_cmp++;
         if (all_ready !== (e >= adv[NS-1])) begin
            n_bad++;
            $display("FAIL %s all_ready edge %0d: got %b expected %b", name, e, all_ready,
                     (e >= adv[NS-1]));
         end
         n_cmp++;
         if (busy !== (e < adv[NS-1])) begin
            n_bad++;
            $display("FAIL %s busy edge %0d: got %b expected %b", name, e, busy, (e < adv[NS-1]));
         end
         n_cmp++;
         if (timeout_err !== exp_err) begin
            n_bad++;
            $display("FAIL %s timeout_err edge %0d: got %b expected %b", name, e, timeout_err,
                     exp_err);
         end
      end
      for (int i = 0; i < NS; i++) begin
         if (tmo[i] && (adv[i] <= last)) err_model[i] = 1'b1;
      end
   endtask

   // Outputs while arst is held, before any release
   task automatic test_reset();
      arst       = 1'b1;
      sw_rst_req = 1'b0;
      ready_in   = '1;
      repeat (2) @(posedge clk);
      #2;
      n_cmp++;
      if ({rst_out, all_ready, busy, timeout_err} !== {3'b111, 1'b0, 1'b1, 3'b000}) begin
         n_bad++;
         $display("FAIL reset_state: got rst=%b rdy=%b busy=%b err=%b expected 111 0 1 000",
                  rst_out, all_ready, busy, timeout_err);
      end
   endtask

   task automatic test_power_up();
      apply_arst();
      play_sequence("power_up", PWR0, 1, 1, 1, 1000);
   endtask

   task automatic test_timeout();
      apply_arst();
      play_sequence("timeout", PWR0, 1, 100000, 1, 1000);
      n_cmp++;
      if (timeout_err !== 3'b010) begin
         n_bad++;
         $display("FAIL timeout_flags: got %b expected 010", timeout_err);
      end
   endtask

   task automatic test_boundary();
      // Ready rising on the cnt==0 edge counts as ready; one edge later is a timeout
      apply_arst();
      play_sequence("boundary_ready", PWR0, PWR0 + TMO, 1, 1, 1000);
      apply_arst();
      play_sequence("boundary_late", PWR0, PWR0 + TMO + 1, 1, 1, 1000);
   endtask

   task automatic test_random();
      for (int k = 0; k < 8; k++) begin
         apply_arst();
         play_sequence("random", PWR0, $urandom_range(1, 35), $urandom_range(1, 35),
                       $urandom_range(1, 35), 1000);
      end
   endtask

   task automatic test_soft_reset();
      apply_arst();
      play_sequence("soft_pre", PWR0, 1, 100000, 1, 1000);
      sw_rst_req = 1'b1;
      ready_in   = '1;
      @(posedge clk);
      #1;
      sw_rst_req = 1'b0;
      n_cmp++;
      if ({rst_out, all_ready, busy, timeout_err} !== {3'b111, 1'b0, 1'b1, err_model}) begin
         n_bad++;
         $display("FAIL soft_reset_edge: got rst=%b rdy=%b busy=%b err=%b expected 111 0 1 %b",
                  rst_out, all_ready, busy, timeout_err, err_model);
      end
      play_sequence("soft_rerun", HC, $urandom_range(1, 20), 1, $urandom_range(1, 20), 1000);
   endtask

   task automatic test_mid_arst();
      apply_arst();
      play_sequence("mid_pre", PWR0, 1, 100000, 1, PWR0 + 4);
      #2;
      arst = 1'b1;
      #1;
      n_cmp++;
      if ({rst_out, all_ready, busy, timeout_err} !== {3'b111, 1'b0, 1'b1, 3'b000}) begin
         n_bad++;
         $display("FAIL mid_arst_async: got rst=%b rdy=%b busy=%b err=%b expected 111 0 1 000",
                  rst_out, all_ready, busy, timeout_err);
      end
      err_model = '0;
      @(posedge clk);
      #1;
      arst = 1'b0;
      play_sequence("mid_rerun", PWR0, 1, 1, 1, 1000);
   endtask

   initial begin
      n_cmp      = 0;
      n_bad      = 0;
      err_model  = '0;
      arst       = 1'b1;
      sw_rst_req = 1'b0;
      ready_in   = '0;
      test_reset();
      test_power_up();
      test_timeout();
      test_boundary();
      test_random();
      test_soft_reset();
      test_mid_arst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
